// File: rtl/iterative_alu.sv
// EX-stage ALU: single-cycle AND/OR/ADD/SUB/SLT plus a multi-cycle radix-2 shift-add MUL.
// Optional macro ALU_EARLY_TERM_EN lets MUL finish as soon as the remaining multiplier is zero.
module iterative_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [2:0]       ALUCtrl_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic [WIDTH-1:0] data_o,
   output logic             zero_o,
   output logic             valid_o,
   output logic             busy_o
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t           r_state, w_next_state;
   logic [WIDTH-1:0] r_acc, r_mcand, r_mplier;
   logic [CW-1:0]    r_cnt, w_cnt_next;
   logic [WIDTH-1:0] r_data;
   logic             r_zero, r_valid;

   logic             w_accept, w_is_mul, w_mul_done, w_load;
   logic [WIDTH-1:0] w_acc_next, w_mplier_shift, w_alu_result, w_result;

   assign w_accept       = valid_i && ready_o;
   assign w_is_mul       = (ALUCtrl_i == OP_MUL);
   assign w_acc_next     = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_mplier_shift = r_mplier >> 1;
   assign w_cnt_next     = r_cnt + CW'(1);

`ifdef ALU_EARLY_TERM_EN
   assign w_mul_done = (r_state == S_MUL) &&
                       ((w_cnt_next == CW'(WIDTH)) || (w_mplier_shift == '0));
`else
   assign w_mul_done = (r_state == S_MUL) && (w_cnt_next == CW'(WIDTH));
`endif

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      w_alu_result = '0;
      case (ALUCtrl_i)
         OP_AND:  w_alu_result = data1_i & data2_i;
         OP_OR:   w_alu_result = data1_i | data2_i;
         OP_ADD:  w_alu_result = data1_i + data2_i;
         OP_SUB:  w_alu_result = data1_i - data2_i;
         OP_SLT:  w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
         default: w_alu_result = '0;
      endcase
   end

   assign w_result = (r_state == S_MUL) ? w_acc_next : w_alu_result;
   assign w_load   = w_mul_done || (w_accept && !w_is_mul);

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_accept && w_is_mul) w_next_state = S_MUL;
         S_MUL:   if (w_mul_done) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      ready_o = (r_state == S_IDLE);
      busy_o  = (r_state != S_IDLE);
   end

   // Multiply registers are cleared on reset so an aborted MUL leaves no residue.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_data   <= '0;
         r_zero   <= 1'b1;
         r_valid  <= 1'b0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end else begin
         r_valid <= w_load;
         if (w_load) begin
            r_data <= w_result;
            r_zero <= (w_result == '0);
         end
         if (w_accept && w_is_mul) begin
            r_acc    <= '0;
            r_mcand  <= data1_i;
            r_mplier <= data2_i;
            r_cnt    <= '0;
         end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_shift;
            r_cnt    <= w_cnt_next;
         end
      end
   end

   assign data_o  = r_data;
   assign zero_o  = r_zero;
   assign valid_o = r_valid;

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu: directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural model (honours ALU_EARLY_TERM_EN when defined).
module tb_iterative_alu;

   localparam int WIDTH = 32;

   localparam logic [2:0] C_AND = 3'b000;
   localparam logic [2:0] C_OR  = 3'b001;
   localparam logic [2:0] C_ADD = 3'b010;
   localparam logic [2:0] C_MUL = 3'b011;
   localparam logic [2:0] C_SUB = 3'b110;
   localparam logic [2:0] C_SLT = 3'b111;

`ifdef ALU_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic             clk_i, rst_i, valid_i, ready_o, zero_o, valid_o, busy_o;
   logic [2:0]       ALUCtrl_i;
   logic [WIDTH-1:0] data1_i, data2_i, data_o;

   int n_total = 0;
   int n_bad   = 0;

   iterative_alu #(.WIDTH(WIDTH)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .ALUCtrl_i (ALUCtrl_i),
      .data1_i   (data1_i),
      .data2_i   (data2_i),
      .data_o    (data_o),
      .zero_o    (zero_o),
      .valid_o   (valid_o),
      .busy_o    (busy_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, bad=%0d", n_bad);
      $fatal(1);
   end

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] model_result(input logic [2:0] op,
                                                      input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
      case (op)
         C_AND:   return a & b;
         C_OR:    return a | b;
         C_ADD:   return a + b;
         C_SUB:   return a - b;
         C_SLT:   return ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
         C_MUL:   return a * b;
         default: return '0;
      endcase
   endfunction

   // Edges from accept to the MUL result edge.
   function automatic int model_latency(input logic [WIDTH-1:0] b);
      if (!EARLY) return WIDTH;
      for (int i = WIDTH - 1; i >= 0; i--)
         if (b[i]) return i + 1;
      return 1;
   endfunction

   // Model: at each falling edge compare, then predict what the next rising edge produces.
   bit               m_known = 1'b0;
   bit               m_busy  = 1'b0;
   bit               m_valid = 1'b0;
   bit               m_zero  = 1'b1;
   logic [WIDTH-1:0] m_data  = '0;
   logic [WIDTH-1:0] m_pend  = '0;
   int               m_left  = 0;

   always @(negedge clk_i) begin
      if (m_known) begin
         check("mdl_valid", WIDTH'(valid_o), WIDTH'(m_valid));
         check("mdl_ready", WIDTH'(ready_o), WIDTH'(!m_busy));
         check("mdl_busy",  WIDTH'(busy_o),  WIDTH'(m_busy));
         check("mdl_data",  data_o,          m_data);
         check("mdl_zero",  WIDTH'(zero_o),  WIDTH'(m_zero));
      end
      m_valid = 1'b0;
      if (rst_i) begin
         m_known = 1'b1;
         m_busy  = 1'b0;
         m_data  = '0;
         m_zero  = 1'b1;
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_busy  = 1'b0;
            m_valid = 1'b1;
            m_data  = m_pend;
            m_zero  = (m_pend == '0);
         end
      end else if (valid_i) begin
         if (ALUCtrl_i == C_MUL) begin
            m_busy = 1'b1;
            m_pend = model_result(ALUCtrl_i, data1_i, data2_i);
            m_left = model_latency(data2_i);
         end else begin
            m_valid = 1'b1;
            m_data  = model_result(ALUCtrl_i, data1_i, data2_i);
            m_zero  = (m_data == '0);
         end
      end
   end

   // Present an op, wait for accept, then count edges after the accept edge until valid_o.
   task automatic run_op(input string name, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp_data, input logic exp_zero,
                         input int exp_edge);
      int budget;
      int j;
      valid_i   = 1'b1;
      ALUCtrl_i = op;
      data1_i   = a;
      data2_i   = b;
      budget    = 0;
      while (!ready_o && budget < 200) begin
         @(posedge clk_i); #1;
         budget++;
      end
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      j = 0;
      while (!valid_o && j < 100) begin
         @(posedge clk_i); #1;
         j++;
      end
      check({name, "_edge"}, WIDTH'(j), WIDTH'(exp_edge));
      check({name, "_data"}, data_o, exp_data);
      check({name, "_zero"}, WIDTH'(zero_o), WIDTH'(exp_zero));
   endtask

   initial begin
      bit seen;
      int j;
      int gaps;
      rst_i     = 1'b1;
      valid_i   = 1'b0;
      ALUCtrl_i = 3'b000;
      data1_i   = '0;
      data2_i   = '0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;

      check("rst_data",  data_o,          WIDTH'(0));
      check("rst_zero",  WIDTH'(zero_o),  WIDTH'(1));
      check("rst_ready", WIDTH'(ready_o), WIDTH'(1));
      check("rst_valid", WIDTH'(valid_o), WIDTH'(0));
      check("rst_busy",  WIDTH'(busy_o),  WIDTH'(0));

      run_op("add", C_ADD, 32'd12, 32'd10, 32'd22, 1'b0, 0);

      // Reset during an in-flight MUL(5,9) must abort it silently.
      valid_i   = 1'b1;
      ALUCtrl_i = C_MUL;
      data1_i   = 32'd5;
      data2_i   = 32'd9;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b1;
      seen = 1'b0;
      repeat (2) begin
         @(posedge clk_i); #1;
         seen |= valid_o;
      end
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      check("abort_data",  data_o,          WIDTH'(0));
      check("abort_zero",  WIDTH'(zero_o),  WIDTH'(1));
      check("abort_ready", WIDTH'(ready_o), WIDTH'(1));
      repeat (40) begin
         @(posedge clk_i); #1;
         seen |= valid_o;
      end
      check("abort_no_valid", WIDTH'(seen), WIDTH'(0));

      run_op("sub",   C_SUB,  32'd12,       32'd10, 32'd2,  1'b0, 0);
      run_op("and",   C_AND,  32'd12,       32'd10, 32'd8,  1'b0, 0);
      run_op("or",    C_OR,   32'd12,       32'd10, 32'd14, 1'b0, 0);
      run_op("undef", 3'b100, 32'd12,       32'd10, 32'd0,  1'b1, 0);
      run_op("slt",   C_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1,  1'b0, 0);
      run_op("slt_n", C_SLT,  32'd1, 32'hFFFF_FFFF, 32'd0,  1'b1, 0);
      run_op("sub_z", C_SUB,  32'd7,        32'd7,  32'd0,  1'b1, 0);

`ifdef ALU_EARLY_TERM_EN
      run_op("et_6x3", C_MUL, 32'd6, 32'd3, 32'd18, 1'b0, 2);
      run_op("et_6x0", C_MUL, 32'd6, 32'd0, 32'd0,  1'b1, 1);
`else
      // MUL(7,6) with an ADD held on valid_i throughout; ADD goes in the MUL's valid_o cycle.
      valid_i   = 1'b1;
      ALUCtrl_i = C_MUL;
      data1_i   = 32'd7;
      data2_i   = 32'd6;
      @(posedge clk_i); #1;
      ALUCtrl_i = C_ADD;
      data1_i   = 32'd12;
      data2_i   = 32'd10;
      j    = 0;
      gaps = 0;
      while (!valid_o && j < 100) begin
         if (!busy_o) gaps++;
         @(posedge clk_i); #1;
         j++;
      end
      check("mul7x6_edge",  WIDTH'(j),       WIDTH'(32));
      check("mul7x6_data",  data_o,          32'd42);
      check("mul7x6_busy",  WIDTH'(gaps),    WIDTH'(0));
      check("mul7x6_ready", WIDTH'(ready_o), WIDTH'(1));
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      check("held_add_valid", WIDTH'(valid_o), WIDTH'(1));
      check("held_add_data",  data_o,          32'd22);
`endif

      run_op("mul_msb",  C_MUL, 32'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32);
      run_op("mul_wrap", C_MUL, 32'h8000_0001, 32'd2, 32'h0000_0002, 1'b0, EARLY ? 2 : 32);

      // Back-to-back: SUB presented in the MUL's valid_o cycle.
      run_op("b2b_mul", C_MUL, 32'd3, 32'd4, 32'd12, 1'b0, EARLY ? 3 : 32);
      check("b2b_overlap", WIDTH'({valid_o, ready_o}), WIDTH'(2'b11));
      run_op("b2b_sub", C_SUB, 32'd5, 32'd9, 32'hFFFF_FFFC, 1'b0, 0);

      repeat (3) @(posedge clk_i);
      #1;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
